// File: rtl/qpsk_demod.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : qpsk_demod                                                    |
// | Purpose  : Coherent QPSK correlator: multiplies each composite sample by |
// |            sine/cosine references, integrates over 100 samples and      |
// |            decides even/odd bits from the correlation signs.            |
// | Option   : QPSK_DEMOD_DEADZONE_EN enables the low-confidence dead zone. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module qpsk_demod #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 32,
  parameter int THRESH = 5000000
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     in_valid,
  input  logic                     sym_start,
  output logic                     E_out,
  output logic                     O_out,
  output logic signed [ACC_W-1:0]  corr_i,
  output logic signed [ACC_W-1:0]  corr_q,
  output logic                     sym_valid,
  output logic                     resync,
  output logic                     low_conf
);

  localparam int         c_REF_W    = 11;
  localparam int         c_PROD_W   = DATA_W + c_REF_W;
  localparam logic [6:0] c_LAST_IDX = 7'd99;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  if (ACC_W < 30 || THRESH < 0) begin : g_param_check
    $error("qpsk_demod: ACC_W must be >= 30 and THRESH must be non-negative");
  end

  // First quadrant of round(1000*sin(2*pi*m/100)), m = 0..25.
  function automatic logic signed [c_REF_W-1:0] quarter_sin(input logic [6:0] m);
    logic signed [c_REF_W-1:0] v;
    case (m)
      7'd0:    v = 11'sd0;
      7'd1:    v = 11'sd63;
      7'd2:    v = 11'sd125;
      7'd3:    v = 11'sd187;
      7'd4:    v = 11'sd249;
      7'd5:    v = 11'sd309;
      7'd6:    v = 11'sd368;
      7'd7:    v = 11'sd426;
      7'd8:    v = 11'sd482;
      7'd9:    v = 11'sd536;
      7'd10:   v = 11'sd588;
      7'd11:   v = 11'sd637;
      7'd12:   v = 11'sd685;
      7'd13:   v = 11'sd729;
      7'd14:   v = 11'sd771;
      7'd15:   v = 11'sd809;
      7'd16:   v = 11'sd844;
      7'd17:   v = 11'sd876;
      7'd18:   v = 11'sd905;
      7'd19:   v = 11'sd930;
      7'd20:   v = 11'sd951;
      7'd21:   v = 11'sd969;
      7'd22:   v = 11'sd982;
      7'd23:   v = 11'sd992;
      7'd24:   v = 11'sd998;
      7'd25:   v = 11'sd1000;
      default: v = 11'sd0;
    endcase
    return v;
  endfunction

  function automatic logic signed [c_REF_W-1:0] sin_ref(input logic [6:0] k);
    logic signed [c_REF_W-1:0] v;
    if (k <= 7'd25)      v = quarter_sin(k);
    else if (k <= 7'd50) v = quarter_sin(7'd50 - k);
    else if (k <= 7'd75) v = -quarter_sin(k - 7'd50);
    else                 v = -quarter_sin(7'd100 - k);
    return v;
  endfunction

  state_t                      r_state;
  logic [6:0]                  r_idx;
  logic signed [c_PROD_W-1:0]  r_p_i;
  logic signed [c_PROD_W-1:0]  r_p_q;
  logic                        r_s1_valid;
  logic                        r_s1_first;
  logic                        r_s1_last;
  logic signed [ACC_W-1:0]     r_acc_i;
  logic signed [ACC_W-1:0]     r_acc_q;
  logic                        r_fin;
  logic signed [ACC_W-1:0]     r_corr_i;
  logic signed [ACC_W-1:0]     r_corr_q;
  logic                        r_e_bit;
  logic                        r_o_bit;
  logic                        r_sym_valid;
  logic                        r_resync;

  logic                        w_accept;
  logic                        w_resync;
  logic [6:0]                  w_idx;
  logic [6:0]                  w_cidx;
  logic signed [c_REF_W-1:0]   w_sin;
  logic signed [c_REF_W-1:0]   w_cos;
  logic signed [ACC_W-1:0]     w_ext_i;
  logic signed [ACC_W-1:0]     w_ext_q;
  logic                        w_pos_i;
  logic                        w_pos_q;

  assign w_accept = in_valid && (r_state == ST_RUN || sym_start);
  assign w_resync = in_valid && sym_start && (r_state == ST_RUN) && (r_idx != 7'd0);
  assign w_idx    = sym_start ? 7'd0 : r_idx;
  // Cosine is the sine table advanced by a quarter period.
  assign w_cidx   = (w_idx < 7'd75) ? (w_idx + 7'd25) : (w_idx - 7'd75);
  assign w_sin    = sin_ref(w_idx);
  assign w_cos    = sin_ref(w_cidx);
  assign w_ext_i  = ACC_W'(r_p_i);
  assign w_ext_q  = ACC_W'(r_p_q);
  assign w_pos_i  = !r_acc_i[ACC_W-1] && (r_acc_i != '0);
  assign w_pos_q  = !r_acc_q[ACC_W-1] && (r_acc_q != '0);

`ifdef QPSK_DEMOD_DEADZONE_EN
  localparam logic [ACC_W-1:0] c_THRESH = ACC_W'(THRESH);
  logic             r_low_conf;
  logic [ACC_W-1:0] w_abs_i;
  logic [ACC_W-1:0] w_abs_q;
  logic             w_dz_i;
  logic             w_dz_q;
  assign w_abs_i  = r_acc_i[ACC_W-1] ? -r_acc_i : r_acc_i;
  assign w_abs_q  = r_acc_q[ACC_W-1] ? -r_acc_q : r_acc_q;
  assign w_dz_i   = w_abs_i < c_THRESH;
  assign w_dz_q   = w_abs_q < c_THRESH;
  assign low_conf = r_low_conf;
`else
  assign low_conf = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_p_i       <= '0;
      r_p_q       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_acc_i     <= '0;
      r_acc_q     <= '0;
      r_fin       <= 1'b0;
      r_corr_i    <= '0;
      r_corr_q    <= '0;
      r_e_bit     <= 1'b0;
      r_o_bit     <= 1'b0;
      r_sym_valid <= 1'b0;
      r_resync    <= 1'b0;
`ifdef QPSK_DEMOD_DEADZONE_EN
      r_low_conf  <= 1'b0;
`endif
    end else begin
      r_s1_valid  <= 1'b0;
      r_fin       <= 1'b0;
      r_sym_valid <= 1'b0;
      r_resync    <= 1'b0;

      if (w_accept) begin
        r_state    <= ST_RUN;
        r_idx      <= (w_idx == c_LAST_IDX) ? 7'd0 : (w_idx + 7'd1);
        r_p_i      <= c_PROD_W'(data_in) * c_PROD_W'(w_sin);
        r_p_q      <= c_PROD_W'(data_in) * c_PROD_W'(w_cos);
        r_s1_valid <= 1'b1;
        r_s1_first <= (w_idx == 7'd0);
        r_s1_last  <= (w_idx == c_LAST_IDX);
        r_resync   <= w_resync;
      end

      // A resync restarts at index 0, so the first flag drops the partial sums.
      if (r_s1_valid) begin
        r_acc_i <= r_s1_first ? w_ext_i : (r_acc_i + w_ext_i);
        r_acc_q <= r_s1_first ? w_ext_q : (r_acc_q + w_ext_q);
        r_fin   <= r_s1_last;
      end

      if (r_fin) begin
        r_corr_i    <= r_acc_i;
        r_corr_q    <= r_acc_q;
        r_sym_valid <= 1'b1;
`ifdef QPSK_DEMOD_DEADZONE_EN
        r_low_conf  <= w_dz_i || w_dz_q;
        if (!w_dz_i) r_e_bit <= w_pos_i;
        if (!w_dz_q) r_o_bit <= w_pos_q;
`else
        r_e_bit     <= w_pos_i;
        r_o_bit     <= w_pos_q;
`endif
      end
    end
  end

  assign E_out     = r_e_bit;
  assign O_out     = r_o_bit;
  assign corr_i    = r_corr_i;
  assign corr_q    = r_corr_q;
  assign sym_valid = r_sym_valid;
  assign resync    = r_resync;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_demod.sv
`default_nettype none
// Testbench for qpsk_demod: directed scenarios plus random traffic, checked
// every cycle against a symbol-level correlation model.
module tb_qpsk_demod;

  localparam int DATA_W = 12;
  localparam int ACC_W  = 32;
  localparam int THRESH = 5000000;

  logic                     Clk = 1'b0;
  logic                     Rst_n = 1'b0;
  logic signed [DATA_W-1:0] data_in = '0;
  logic                     in_valid = 1'b0;
  logic                     sym_start = 1'b0;
  logic                     E_out, O_out, sym_valid, resync, low_conf;
  logic signed [ACC_W-1:0]  corr_i, corr_q;

  qpsk_demod #(.DATA_W(DATA_W), .ACC_W(ACC_W), .THRESH(THRESH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .data_in(data_in), .in_valid(in_valid),
    .sym_start(sym_start), .E_out(E_out), .O_out(O_out), .corr_i(corr_i),
    .corr_q(corr_q), .sym_valid(sym_valid), .resync(resync), .low_conf(low_conf)
  );

  always #5 Clk = ~Clk;

  int     checks = 0;
  int     errors = 0;
  int     cycle  = 0;
  int     sin_ref [100];
  int     cos_ref [100];

  // Reference model: symbol sums, a 2-cycle result delay and held outputs.
  bit     m_run;
  int     m_idx;
  longint m_si, m_sq;
  bit     lat_v [2];
  longint lat_i [2];
  longint lat_q [2];
  bit     exp_e, exp_o, exp_lc, exp_sv, exp_rs;
  longint exp_ci, exp_cq;

  int     sv_count, rs_count, last_sample_cycle;
  int     sv_cycles[$];
  longint sv_ci[$], sv_cq[$];
  bit     sv_e[$], sv_o[$];

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_idx = 0; m_si = 0; m_sq = 0;
    lat_v[0] = 0; lat_v[1] = 0;
    exp_e = 0; exp_o = 0; exp_lc = 0; exp_sv = 0; exp_rs = 0;
    exp_ci = 0; exp_cq = 0;
  endtask

  task automatic decide(input longint ci, input longint cq);
    bit dz_i, dz_q;
    exp_ci = ci;
    exp_cq = cq;
    dz_i = ((ci < 0) ? -ci : ci) < THRESH;
    dz_q = ((cq < 0) ? -cq : cq) < THRESH;
`ifdef QPSK_DEMOD_DEADZONE_EN
    exp_lc = dz_i || dz_q;
    if (!dz_i) exp_e = (ci > 0);
    if (!dz_q) exp_o = (cq > 0);
`else
    exp_lc = 0;
    exp_e  = (ci > 0);
    exp_o  = (cq > 0);
    if (dz_i && dz_q && ci > THRESH) exp_lc = 1;
`endif
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "sym_valid"}, sym_valid, exp_sv);
    chk({pfx, "resync"},    resync,    exp_rs);
    chk({pfx, "E_out"},     E_out,     exp_e);
    chk({pfx, "O_out"},     O_out,     exp_o);
    chk({pfx, "low_conf"},  low_conf,  exp_lc);
    chk({pfx, "corr_i"},    64'(corr_i), exp_ci);
    chk({pfx, "corr_q"},    64'(corr_q), exp_cq);
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit v, input bit ss, input int d);
    int idx;
    data_in   = DATA_W'(d);
    in_valid  = v;
    sym_start = ss;
    exp_sv = 0;
    exp_rs = 0;
    if (lat_v[1]) begin
      exp_sv = 1;
      decide(lat_i[1], lat_q[1]);
    end
    lat_v[1] = lat_v[0]; lat_i[1] = lat_i[0]; lat_q[1] = lat_q[0];
    lat_v[0] = 0;
    if (v && (m_run || ss)) begin
      if (ss && m_run && m_idx != 0) exp_rs = 1;
      idx = ss ? 0 : m_idx;
      if (idx == 0) begin m_si = 0; m_sq = 0; end
      m_si += longint'(d) * sin_ref[idx];
      m_sq += longint'(d) * cos_ref[idx];
      if (idx == 99) begin lat_v[0] = 1; lat_i[0] = m_si; lat_q[0] = m_sq; end
      m_idx = (idx + 1) % 100;
      m_run = 1;
    end
    @(posedge Clk);
    #1;
    cycle++;
    check_outputs("");
    if (sym_valid === 1'b1) begin
      sv_count++;
      sv_cycles.push_back(cycle);
      sv_ci.push_back(longint'(corr_i));
      sv_cq.push_back(longint'(corr_q));
      sv_e.push_back(E_out);
      sv_o.push_back(O_out);
    end
    if (resync === 1'b1) rs_count++;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, int'($urandom_range(1000, 0)));
  endtask

  // Modulator-like symbol: +/-sin +/-cos per bit, optional noise and gaps.
  task automatic send_symbol(input bit e, input bit o, input int noise,
                             input int gap_every, input int n);
    for (int k = 0; k < n; k++) begin
      int s;
      s = (e ? sin_ref[k] : -sin_ref[k]) + (o ? cos_ref[k] : -cos_ref[k]);
      if (noise > 0) s += int'($urandom_range(2 * noise, 0)) - noise;
      cyc(1, k == 0, s);
      if (k == n - 1) last_sample_cycle = cycle;
      if (gap_every > 0 && (k % gap_every) == gap_every - 1)
        repeat (3) cyc(0, 0, int'($urandom_range(2000, 0)) - 1000);
    end
  endtask

  task automatic async_reset();
    #1;
    Rst_n = 1'b0;
    in_valid = 1'b0;
    sym_start = 1'b0;
    #2;
    model_reset();
    check_outputs("async_rst_");
    @(posedge Clk);
    #1;
    cycle++;
    Rst_n = 1'b1;
  endtask

  initial begin
    int b, sv0, rs0;
    longint ref_ci, ref_cq;
    real pi;
    pi = 3.14159265358979323846;
    for (int k = 0; k < 100; k++) begin
      sin_ref[k] = $rtoi($floor(1000.0 * $sin(2.0 * pi * k / 100.0) + 0.5));
      cos_ref[k] = $rtoi($floor(1000.0 * $cos(2.0 * pi * k / 100.0) + 0.5));
    end
    model_reset();
    sv_count = 0; rs_count = 0; last_sample_cycle = 0;

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check_outputs("reset_");
    Rst_n = 1'b1;
    flush(3);

    // Clean 11 symbol: latency, bits, correlation magnitude
    sv0 = sv_count;
    send_symbol(1, 1, 0, 0, 100);
    ref_ci = m_si; ref_cq = m_sq;
    flush(4);
    chk("t1_pulses", sv_count - sv0, 1);
    chk("t1_latency", sv_cycles[sv_cycles.size()-1] - last_sample_cycle, 2);
    chk("t1_E", sv_e[sv_e.size()-1], 1);
    chk("t1_O", sv_o[sv_o.size()-1], 1);
    chk("t1_ci_tol", (sv_ci[sv_ci.size()-1] > 49900000 && sv_ci[sv_ci.size()-1] < 50100000), 1);
    chk("t1_cq_tol", (sv_cq[sv_cq.size()-1] > 49900000 && sv_cq[sv_cq.size()-1] < 50100000), 1);

    // Four back-to-back symbols 10, 01, 00, 11
    b = sv_cycles.size();
    send_symbol(1, 0, 100, 0, 100);
    send_symbol(0, 1, 100, 0, 100);
    send_symbol(0, 0, 100, 0, 100);
    send_symbol(1, 1, 100, 0, 100);
    flush(4);
    chk("t2_pulses", sv_cycles.size() - b, 4);
    if (sv_cycles.size() - b == 4) begin
      for (int i = 1; i < 4; i++) chk("t2_spacing", sv_cycles[b+i] - sv_cycles[b+i-1], 100);
      chk("t2_bits0", {sv_e[b],   sv_o[b]},   2'b10);
      chk("t2_bits1", {sv_e[b+1], sv_o[b+1]}, 2'b01);
      chk("t2_bits2", {sv_e[b+2], sv_o[b+2]}, 2'b00);
      chk("t2_bits3", {sv_e[b+3], sv_o[b+3]}, 2'b11);
      chk("t2_signs", {sv_ci[b] > 0, sv_cq[b] < 0, sv_ci[b+1] < 0, sv_cq[b+1] > 0,
                       sv_ci[b+2] < 0, sv_cq[b+2] < 0, sv_ci[b+3] > 0, sv_cq[b+3] > 0}, 8'hFF);
    end

    // Same clean 11 symbol with 3-cycle gaps every 10 samples
    sv0 = sv_count;
    send_symbol(1, 1, 0, 10, 100);
    flush(4);
    chk("t3_pulses", sv_count - sv0, 1);
    chk("t3_corr_i_same", sv_ci[sv_ci.size()-1], ref_ci);
    chk("t3_corr_q_same", sv_cq[sv_cq.size()-1], ref_cq);

    // Resync at index 40, then a full 01 symbol
    sv0 = sv_count; rs0 = rs_count;
    send_symbol(1, 0, 50, 0, 40);
    send_symbol(0, 1, 50, 0, 100);
    flush(4);
    chk("t4_resync_count", rs_count - rs0, 1);
    chk("t4_pulses", sv_count - sv0, 1);
    chk("t4_bits", {sv_e[sv_e.size()-1], sv_o[sv_o.size()-1]}, 2'b01);

    // Reset at index 57: IDLE ignores data until a new sym_start
    send_symbol(1, 1, 0, 0, 57);
    async_reset();
    sv0 = sv_count;
    for (int k = 0; k < 120; k++) cyc(1, 0, int'($urandom_range(2000, 0)) - 1000);
    flush(3);
    chk("t5_no_pulse", sv_count - sv0, 0);
    send_symbol(0, 0, 50, 0, 100);
    flush(4);
    chk("t5_pulse_after", sv_count - sv0, 1);
    chk("t5_bits", {sv_e[sv_e.size()-1], sv_o[sv_o.size()-1]}, 2'b00);

    // 11 symbol followed by an all-zero symbol
    send_symbol(1, 1, 0, 0, 100);
    for (int k = 0; k < 100; k++) cyc(1, k == 0, 0);
    flush(4);
    chk("t6_corr_i_zero", 64'(corr_i), 0);
    chk("t6_corr_q_zero", 64'(corr_q), 0);
`ifdef QPSK_DEMOD_DEADZONE_EN
    chk("t6_low_conf", low_conf, 1);
    chk("t6_bits_held", {E_out, O_out}, 2'b11);
`else
    chk("t6_low_conf", low_conf, 0);
    chk("t6_bits_zero", {E_out, O_out}, 2'b00);
`endif

    // Random traffic: random valid gaps, occasional sym_start anywhere
    for (int k = 0; k < 600; k++)
      cyc($urandom_range(3, 0) != 0, $urandom_range(60, 0) == 0,
          int'($urandom_range(3000, 0)) - 1500);
    for (int k = 0; k < 100; k++)
      cyc(1, k == 0, int'($urandom_range(3000, 0)) - 1500);
    flush(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
